ahb_master: RTL and testbench
=============================

AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, is the maximum number of consecutive hready-low data-phase cycles before abort.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request from the local side.
REQ-005 cmd_ready  output  1  master can accept a command.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  byte address.
REQ-008 cmd_wdata  input  32  write data, right-justified.
REQ-009 cmd_size  input  3  000 byte, 001 halfword, 010 word.
REQ-010 cmd_signed  input  1  read sign-extension request.
REQ-011 haddr, hwrite, hsize[2:0], hwdata[31:0], is_signed  output  AHB address/data-phase signals toward the slave.
REQ-012 htrans  output  2  00 IDLE, 10 NONSEQ.
REQ-013 hrdata  input  32  read data; hready input 1; hresp input 1 (0 OKAY, 1 ERROR).
REQ-014 resp_valid  output  1  one-cycle completion pulse; resp_rdata output 32; resp_err output 1; resp_timeout output 1.

Function
REQ-015 FSM states are IDLE, ADDR and DATA; cmd_ready SHALL equal (state==IDLE).
REQ-016 Handshake: a command is taken at an edge with cmd_valid && cmd_ready; commands have no backpressure on the response side.
REQ-017 Legality check at acceptance: cmd_size > 010, a halfword with addr[0]=1, or a word with addr[1:0]!=00 is illegal; the master SHALL issue no bus transfer, pulse resp_valid with resp_err=1 in the next cycle, and stay in IDLE.
REQ-018 Legal accept: go to ADDR; drive htrans=10, haddr=cmd_addr, hwrite, hsize=cmd_size, is_signed from registers.
REQ-019 In ADDR at an edge with hready=1: go to DATA, drive htrans=00 and hwdata=cmd_wdata masked to size (upper bytes 0), and clear the wait counter; with hready=0, hold all address-phase outputs.
REQ-020 In DATA at an edge with hready=1: pulse resp_valid, set resp_err=hresp and resp_timeout=0, then go to IDLE.
REQ-021 On a DATA-phase read completion, resp_rdata SHALL be hrdata[7:0] or hrdata[15:0] extended per cmd_signed (sign- or zero-extension), or the full word for word size; writes return 0.
REQ-022 AHB two-cycle ERROR: the first cycle (hready=0, hresp=1) is waited through; completion occurs on the hready=1 cycle with resp_err=1.
REQ-023 Timeout: in DATA, each hready=0 edge increments the wait counter; when the counter reaches TIMEOUT_CYCLES-1 and hready is still 0, pulse resp_valid with resp_err=1 and resp_timeout=1, and go to IDLE; late hready/hrdata are ignored.
REQ-024 Zero-wait latency: accept at edge E0, ADDR after E0, DATA after E1, resp_valid high after E2; cmd_ready is high in the same cycle as resp_valid.
REQ-025 Outside an address phase, htrans SHALL be 00, and haddr/hwrite/hsize SHALL hold their last values.
REQ-026 resp_rdata, resp_err and resp_timeout SHALL hold their values until the next resp_valid.

Reset
REQ-027 While reset is high: state=IDLE, htrans=00, haddr=0, hwrite=0, hsize=000, hwdata=0, is_signed=0, resp_valid=0, resp_rdata=0, resp_err=0, resp_timeout=0, wait counter=0.
REQ-028 Reset asserted in ADDR or DATA SHALL abandon the transfer with no resp_valid pulse; cmd_ready=1 in the first cycle after reset deasserts.

Structure
REQ-029 A shared package ahb_pkg SHALL hold the HTRANS codes (IDLE, NONSEQ), the HSIZE codes (BYTE, HALF, WORD), the HRESP codes and the FSM state enum.
REQ-030 One sub-module, ahb_rdata_ext (combinational size/sign extender), SHALL implement REQ-021.

Verification
REQ-031 Bench pairs ahb_master with the team's RAM slave (bytes 0..4 = AA BB CC DD EE after reset) and an hready/hresp-injecting slave model.
REQ-032 Read word at 0x0, zero wait -> resp_valid two cycles after accept, resp_rdata=0xDDCCBBAA, resp_err=0.
REQ-033 Signed byte read at 0x4 -> 0xFFFFFFEE; unsigned -> 0x000000EE; signed halfword read at 0x2 -> 0xFFFFDDCC.
REQ-034 Halfword write 0x00001234 at 0x8, then halfword read at 0x8 -> 0x00001234; hwdata observed = 0x00001234.
REQ-035 Word command at 0x2 -> htrans stays 00 throughout, resp_err=1 one cycle after accept; hsize=011 behaves the same.
REQ-036 Slave holds hready=0 for 20 cycles -> resp_timeout=1 after 16 wait cycles; an injected ERROR response -> resp_err=1, resp_timeout=0; reset pulsed in DATA -> no resp_valid, all outputs at reset values.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB constants, FSM state type and command helpers for the single-transfer
// AHB-Lite master.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  // Sizes above a word and misaligned halfword/word accesses never reach the bus.
  function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
    logic ok;
    ok = 1'b0;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lsb[0];
      HSIZE_WORD: ok = (addr_lsb == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Write data is right-justified; bytes above the transfer size are driven as zero.
  function automatic logic [31:0] size_mask(input logic [2:0] size);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    if (size == HSIZE_BYTE) begin
      m = 32'h0000_00FF;
    end else if (size == HSIZE_HALF) begin
      m = 32'h0000_FFFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/ahb_rdata_ext.sv
// Combinational read-data extender: keeps the low byte/halfword/word of hrdata and
// fills the remaining lanes with zeros or the sign bit.
module ahb_rdata_ext
  import ahb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  size,
  input  logic        sign_ext,
  output logic [31:0] ext_data
);

  logic fill;

  always_comb begin
    fill = 1'b0;
    if (sign_ext) begin
      if (size == HSIZE_BYTE) begin
        fill = rdata[7];
      end else if (size == HSIZE_HALF) begin
        fill = rdata[15];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic keep;
      assign keep = (gi == 0) ||
                    ((size == HSIZE_HALF) && (gi < 2)) ||
                    (size == HSIZE_WORD);
      assign ext_data[8*gi +: 8] = keep ? rdata[8*gi +: 8] : {8{fill}};
    end
  endgenerate

endmodule

// File: rtl/ahb_master.sv
// Single-outstanding AHB-Lite master: one local command becomes one NONSEQ transfer,
// with legality screening, read extension and a data-phase wait timeout.
module ahb_master
  import ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [2:0]  cmd_size,
  input  logic        cmd_signed,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [31:0] hwdata,
  output logic        is_signed,
  output logic [1:0]  htrans,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [1:0]        htrans_reg, htrans_next;
  logic [31:0]       haddr_reg, haddr_next;
  logic              hwrite_reg, hwrite_next;
  logic [2:0]        hsize_reg, hsize_next;
  logic              is_signed_reg, is_signed_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       hwdata_reg, hwdata_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              resp_valid_reg, resp_valid_next;
  logic [31:0]       resp_rdata_reg, resp_rdata_next;
  logic              resp_err_reg, resp_err_next;
  logic              resp_timeout_reg, resp_timeout_next;
  logic [31:0]       ext_rdata;

  ahb_rdata_ext u_rdata_ext (
    .rdata    (hrdata),
    .size     (hsize_reg),
    .sign_ext (is_signed_reg),
    .ext_data (ext_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      htrans_reg       <= HTRANS_IDLE;
      haddr_reg        <= '0;
      hwrite_reg       <= 1'b0;
      hsize_reg        <= HSIZE_BYTE;
      is_signed_reg    <= 1'b0;
      wdata_reg        <= '0;
      hwdata_reg       <= '0;
      wait_cnt_reg     <= '0;
      resp_valid_reg   <= 1'b0;
      resp_rdata_reg   <= '0;
      resp_err_reg     <= 1'b0;
      resp_timeout_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      htrans_reg       <= htrans_next;
      haddr_reg        <= haddr_next;
      hwrite_reg       <= hwrite_next;
      hsize_reg        <= hsize_next;
      is_signed_reg    <= is_signed_next;
      wdata_reg        <= wdata_next;
      hwdata_reg       <= hwdata_next;
      wait_cnt_reg     <= wait_cnt_next;
      resp_valid_reg   <= resp_valid_next;
      resp_rdata_reg   <= resp_rdata_next;
      resp_err_reg     <= resp_err_next;
      resp_timeout_reg <= resp_timeout_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    htrans_next       = htrans_reg;
    haddr_next        = haddr_reg;
    hwrite_next       = hwrite_reg;
    hsize_next        = hsize_reg;
    is_signed_next    = is_signed_reg;
    wdata_next        = wdata_reg;
    hwdata_next       = hwdata_reg;
    wait_cnt_next     = wait_cnt_reg;
    resp_valid_next   = 1'b0;
    resp_rdata_next   = resp_rdata_reg;
    resp_err_next     = resp_err_reg;
    resp_timeout_next = resp_timeout_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_legal(cmd_size, cmd_addr[1:0])) begin
            state_next     = ST_ADDR;
            htrans_next    = HTRANS_NONSEQ;
            haddr_next     = cmd_addr;
            hwrite_next    = cmd_write;
            hsize_next     = cmd_size;
            is_signed_next = cmd_signed;
            wdata_next     = cmd_wdata;
          end else begin
            // Rejected locally: answer next cycle without touching the bus.
            resp_valid_next   = 1'b1;
            resp_err_next     = 1'b1;
            resp_timeout_next = 1'b0;
            resp_rdata_next   = '0;
          end
        end
      end

      ST_ADDR: begin
        if (hready) begin
          state_next    = ST_DATA;
          htrans_next   = HTRANS_IDLE;
          hwdata_next   = wdata_reg & size_mask(hsize_reg);
          wait_cnt_next = '0;
        end
      end

      ST_DATA: begin
        if (hready) begin
          state_next        = ST_IDLE;
          resp_valid_next   = 1'b1;
          resp_err_next     = (hresp == HRESP_ERROR);
          resp_timeout_next = 1'b0;
          resp_rdata_next   = hwrite_reg ? 32'h0 : ext_rdata;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          // Slave stalled too long; whatever it returns later is dropped.
          state_next        = ST_IDLE;
          resp_valid_next   = 1'b1;
          resp_err_next     = 1'b1;
          resp_timeout_next = 1'b1;
          resp_rdata_next   = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready    = (state_reg == ST_IDLE);
  assign htrans       = htrans_reg;
  assign haddr        = haddr_reg;
  assign hwrite       = hwrite_reg;
  assign hsize        = hsize_reg;
  assign is_signed    = is_signed_reg;
  assign hwdata       = hwdata_reg;
  assign resp_valid   = resp_valid_reg;
  assign resp_rdata   = resp_rdata_reg;
  assign resp_err     = resp_err_reg;
  assign resp_timeout = resp_timeout_reg;

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: byte-array RAM slave with injectable hready/hresp and a
// byte-level reference model of memory contents and read extension.
module tb_ahb_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_signed;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, is_signed, hready, hresp;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        resp_valid, resp_err, resp_timeout;
  logic [31:0] resp_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size), .cmd_signed(cmd_signed),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .is_signed(is_signed),
    .htrans(htrans), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_timeout(resp_timeout)
  );

  // RAM slave: 32 bytes, right-justified data, reloaded on reset
  logic [7:0] mem [32];
  logic       dp_active, dp_write;
  logic [4:0] dp_addr;
  logic [2:0] dp_size;

  always @(posedge clk) begin
    if (reset) begin
      dp_active <= 1'b0;
      dp_addr   <= 5'd0;
      dp_write  <= 1'b0;
      dp_size   <= 3'd0;
      for (int i = 0; i < 32; i++) mem[i] <= (i < 5) ? 8'(170 + 17 * i) : 8'h00;
    end else begin
      if (dp_active && hready) begin
        dp_active <= 1'b0;
        if (dp_write)
          for (int i = 0; i < 4; i++)
            if (i < (1 << dp_size)) mem[5'(dp_addr + 5'(i))] <= hwdata[8*i +: 8];
      end
      if (htrans == 2'b10 && hready) begin
        dp_active <= 1'b1;
        dp_addr   <= haddr[4:0];
        dp_write  <= hwrite;
        dp_size   <= hsize;
      end
    end
  end

  assign hrdata = {mem[5'(dp_addr + 5'd3)], mem[5'(dp_addr + 5'd2)],
                   mem[5'(dp_addr + 5'd1)], mem[dp_addr]};

  // Reference model
  logic [7:0] model_mem [32];

  task automatic model_reset;
    for (int i = 0; i < 32; i++) model_mem[i] = (i < 5) ? 8'(170 + 17 * i) : 8'h00;
  endtask

  function automatic logic model_legal(input logic [31:0] addr, input logic [2:0] size);
    if (size > 3'd2) return 1'b0;
    if (size == 3'd1 && (addr % 2) != 0) return 1'b0;
    if (size == 3'd2 && (addr % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [2:0] size,
                                             input logic sgn);
    int n;
    longint v;
    n = 1 << size;
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(model_mem[(addr + i) % 32]) << (8 * i));
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_wmask(input logic [31:0] wdata, input logic [2:0] size);
    int n;
    n = 1 << size;
    if (n >= 4) return wdata;
    return 32'(longint'(wdata) % (longint'(1) << (8 * n)));
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata);
    for (int i = 0; i < (1 << size); i++) model_mem[(addr + i) % 32] = wdata[8*i +: 8];
  endtask

  // mode 0: zero wait, 1: random waits, 2: hready low 20 cycles in data, 3: two-cycle ERROR
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic sgn, input logic [31:0] wdata, input int mode,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output logic tmo, output logic saw_trans, output logic [31:0] wd_seen);
    int lows;
    lat = 0; lows = 0; saw_trans = 1'b0;
    rdata = 32'h0; err = 1'b0; tmo = 1'b0; wd_seen = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size;
    cmd_signed = sgn; cmd_wdata = wdata; hready = 1'b1; hresp = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (htrans !== 2'b00) saw_trans = 1'b1;
      if (resp_valid === 1'b1) begin
        lat = k; rdata = resp_rdata; err = resp_err; tmo = resp_timeout; wd_seen = hwdata;
        break;
      end
      case (mode)
        1: begin
          if (lows < 3 && $urandom_range(0, 2) == 0) begin hready = 1'b0; lows++; end
          else begin hready = 1'b1; lows = 0; end
        end
        2: hready = !(k >= 2 && k < 22);
        3: begin hready = (k != 2); hresp = (k == 2 || k == 3); end
        default: hready = 1'b1;
      endcase
    end
    hready = 1'b1; hresp = 1'b0;
    checks++;
    if (lat == 0) begin
      failures++;
      $display("FAIL resp_wait_budget got=no_resp_valid exp=resp_valid_within_60_cycles");
    end
    $display("txn wr=%0b addr=%08h size=%0d sgn=%0b wdata=%08h mode=%0d -> lat=%0d rdata=%08h err=%0b tmo=%0b",
             wr, addr, size, sgn, wdata, mode, lat, rdata, err, tmo);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({htrans, haddr, hwdata, resp_rdata} !== 98'h0) begin
      failures++;
      $display("FAIL %s_bus got=htrans %b haddr %h hwdata %h rdata %h exp=all_zero",
               tag, htrans, haddr, hwdata, resp_rdata);
    end
    checks++;
    if ({hwrite, hsize, is_signed, resp_valid, resp_err, resp_timeout} !== 8'h00) begin
      failures++;
      $display("FAIL %s_flags got=%b exp=00000000", tag,
               {hwrite, hsize, is_signed, resp_valid, resp_err, resp_timeout});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_cmd_ready got=%b exp=1", tag, cmd_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    cmd_size = 3'd0; cmd_signed = 1'b0; hready = 1'b1; hresp = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_read_word;
    int lat; logic [31:0] rd, wd; logic er, tm, st;
    run_cmd(1'b0, 32'h0, 3'd2, 1'b0, 32'h0, 0, lat, rd, er, tm, st, wd);
    checks++;
    if (lat != 3) begin failures++; $display("FAIL word_latency got=%0d exp=3", lat); end
    checks++;
    if (rd !== 32'hDDCCBBAA) begin failures++; $display("FAIL word_rdata got=%h exp=ddccbbaa", rd); end
    checks++;
    if ({er, tm} !== 2'b00) begin failures++; $display("FAIL word_err got=%b exp=00", {er, tm}); end
  endtask

  task automatic test_signed_reads;
    int lat; logic [31:0] rd, wd; logic er, tm, st;
    run_cmd(1'b0, 32'h4, 3'd0, 1'b1, 32'h0, 0, lat, rd, er, tm, st, wd);
    checks++;
    if (rd !== 32'hFFFFFFEE) begin failures++; $display("FAIL sbyte_rdata got=%h exp=ffffffee", rd); end
    run_cmd(1'b0, 32'h4, 3'd0, 1'b0, 32'h0, 0, lat, rd, er, tm, st, wd);
    checks++;
    if (rd !== 32'h000000EE) begin failures++; $display("FAIL ubyte_rdata got=%h exp=000000ee", rd); end
    run_cmd(1'b0, 32'h2, 3'd1, 1'b1, 32'h0, 0, lat, rd, er, tm, st, wd);
    checks++;
    if (rd !== 32'hFFFFDDCC) begin failures++; $display("FAIL shalf_rdata got=%h exp=ffffddcc", rd); end
  endtask

  task automatic test_write_read;
    int lat; logic [31:0] rd, wd; logic er, tm, st;
    run_cmd(1'b1, 32'h8, 3'd1, 1'b0, 32'hFFFF1234, 0, lat, rd, er, tm, st, wd);
    model_write(32'h8, 3'd1, 32'hFFFF1234);
    checks++;
    if (wd !== 32'h00001234) begin failures++; $display("FAIL half_hwdata got=%h exp=00001234", wd); end
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      failures++; $display("FAIL write_resp got=rdata %h err %b exp=rdata 0 err 0", rd, er);
    end
    checks++;
    if (haddr !== 32'h8 || hsize !== 3'd1 || htrans !== 2'b00) begin
      failures++;
      $display("FAIL addr_hold got=haddr %h hsize %0d htrans %b exp=haddr 8 hsize 1 htrans 00",
               haddr, hsize, htrans);
    end
    run_cmd(1'b0, 32'h8, 3'd1, 1'b0, 32'h0, 0, lat, rd, er, tm, st, wd);
    checks++;
    if (rd !== 32'h00001234) begin failures++; $display("FAIL half_readback got=%h exp=00001234", rd); end
  endtask

  task automatic test_illegal;
    int lat; logic [31:0] rd, wd; logic er, tm, st;
    logic [31:0] addrs [3];
    logic [2:0]  sizes [3];
    addrs[0] = 32'h2; sizes[0] = 3'd2;
    addrs[1] = 32'h0; sizes[1] = 3'd3;
    addrs[2] = 32'h1; sizes[2] = 3'd1;
    for (int j = 0; j < 3; j++) begin
      run_cmd(1'b0, addrs[j], sizes[j], 1'b0, 32'h0, 0, lat, rd, er, tm, st, wd);
      checks++;
      if (lat != 1 || er !== 1'b1 || tm !== 1'b0) begin
        failures++;
        $display("FAIL illegal_resp[%0d] got=lat %0d err %b tmo %b exp=lat 1 err 1 tmo 0", j, lat, er, tm);
      end
      @(negedge clk);
      checks++;
      if (st !== 1'b0 || htrans !== 2'b00 || cmd_ready !== 1'b1 || resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL illegal_bus[%0d] got=trans_seen %b htrans %b ready %b rv %b exp=0 00 1 0",
                 j, st, htrans, cmd_ready, resp_valid);
      end
    end
  endtask

  task automatic test_error;
    int lat; logic [31:0] rd, wd; logic er, tm, st;
    run_cmd(1'b0, 32'h0, 3'd2, 1'b0, 32'h0, 3, lat, rd, er, tm, st, wd);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL error_latency got=%0d exp=4", lat); end
    checks++;
    if (er !== 1'b1 || tm !== 1'b0) begin
      failures++; $display("FAIL error_flags got=err %b tmo %b exp=err 1 tmo 0", er, tm);
    end
  endtask

  task automatic test_timeout;
    int lat; logic [31:0] rd, wd; logic er, tm, st;
    logic late;
    run_cmd(1'b0, 32'h1, 3'd0, 1'b0, 32'h0, 2, lat, rd, er, tm, st, wd);
    checks++;
    if (lat != 2 + TO) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, 2 + TO); end
    checks++;
    if (er !== 1'b1 || tm !== 1'b1) begin
      failures++; $display("FAIL timeout_flags got=err %b tmo %b exp=err 1 tmo 1", er, tm);
    end
    hready = 1'b0;
    late = 1'b0;
    repeat (3) @(negedge clk);
    hready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) late = 1'b1;
    end
    checks++;
    if (late !== 1'b0 || tm !== resp_timeout) begin
      failures++; $display("FAIL timeout_late_ignored got=late_pulse %b tmo %b exp=0 1", late, resp_timeout);
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd, wd; logic er, tm, st;
    logic wr, sgn, leg;
    logic [31:0] addr, wdata, exp_rd;
    logic [2:0] sz;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 31));
      if (sz <= 3'd2 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      wdata = $urandom;
      leg = model_legal(addr, sz);
      exp_rd = (leg && !wr) ? model_read(addr, sz, sgn) : 32'h0;
      run_cmd(wr, addr, sz, sgn, wdata, 1, lat, rd, er, tm, st, wd);
      if (leg && wr) model_write(addr, sz, wdata);
      checks++;
      if (er !== !leg || tm !== 1'b0) begin
        failures++; $display("FAIL rnd_err[%0d] got=err %b tmo %b exp=err %b tmo 0", t, er, tm, !leg);
      end
      checks++;
      if ((leg && lat < 3) || (!leg && lat != 1) || st !== leg) begin
        failures++; $display("FAIL rnd_timing[%0d] got=lat %0d trans %b exp_legal=%b", t, lat, st, leg);
      end
      if (leg) begin
        checks++;
        if (rd !== exp_rd) begin failures++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", t, rd, exp_rd); end
      end
      if (leg && wr) begin
        checks++;
        if (wd !== model_wmask(wdata, sz)) begin
          failures++; $display("FAIL rnd_hwdata[%0d] got=%h exp=%h", t, wd, model_wmask(wdata, sz));
        end
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || resp_err !== !leg || (leg && resp_rdata !== exp_rd)) begin
        failures++;
        $display("FAIL rnd_hold[%0d] got=rv %b err %b rdata %h exp=rv 0 err %b rdata %h",
                 t, resp_valid, resp_err, resp_rdata, !leg, exp_rd);
      end
    end
  endtask

  task automatic test_reset_in_data;
    logic pulse;
    pulse = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4; cmd_size = 3'd2;
    cmd_signed = 1'b1; cmd_wdata = 32'h0; hready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    hready = 1'b0;
    if (resp_valid !== 1'b0) pulse = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    if (resp_valid !== 1'b0) pulse = 1'b1;
    @(negedge clk);
    if (resp_valid !== 1'b0) pulse = 1'b1;
    check_reset_values("rst_in_data");
    reset = 1'b0; hready = 1'b1;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) pulse = 1'b1;
    end
    checks++;
    if (pulse !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL rst_in_data_abandon got=pulse %b ready %b exp=pulse 0 ready 1", pulse, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_read_word();
    test_signed_reads();
    test_write_read();
    test_illegal();
    test_error();
    test_timeout();
    test_random();
    test_reset_in_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
